// File: rtl/r4_sdf_butterfly_pkg.sv
// rtl/r4_sdf_butterfly_pkg.sv - shared widths, complex types and unit twiddle for the radix-4 SDF stage
package r4_sdf_butterfly_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TW_FRAC = DEF_WIDTH / 2 - 2;
  localparam int TW_ONE      = 1 << DEF_TW_FRAC;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] re;
    logic signed [DEF_WIDTH-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [DEF_WIDTH/2-1:0] re;
    logic signed [DEF_WIDTH/2-1:0] im;
  } twiddle_t;

endpackage

// File: rtl/sdf_delay_line.sv
// rtl/sdf_delay_line.sv - complex shift-register feedback buffer, output is the entry written DEPTH enables ago
module sdf_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);

  logic [WIDTH-1:0] re_q [DEPTH];
  logic [WIDTH-1:0] im_q [DEPTH];

  // No reset: this is pure storage and its contents are only meaningful after DEPTH writes.
  always_ff @(posedge clock) begin
    if (enable) begin
      re_q[0] <= in_re;
      im_q[0] <= in_im;
      for (int i = 1; i < DEPTH; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end
  end

  assign out_re = re_q[DEPTH-1];
  assign out_im = im_q[DEPTH-1];

endmodule

// File: rtl/r4_sdf_butterfly.sv
// rtl/r4_sdf_butterfly.sv - two-stage pipelined radix-4 DIF butterfly with twiddle rotation of outputs 2..4
module r4_sdf_butterfly
  import r4_sdf_butterfly_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TW_FRAC = WIDTH / 2 - 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      done,
  input  logic signed [WIDTH-1:0]   ar,
  input  logic signed [WIDTH-1:0]   ai,
  input  logic signed [WIDTH-1:0]   br,
  input  logic signed [WIDTH-1:0]   bi,
  input  logic signed [WIDTH-1:0]   cr,
  input  logic signed [WIDTH-1:0]   ci,
  input  logic signed [WIDTH-1:0]   dr,
  input  logic signed [WIDTH-1:0]   di,
  input  logic signed [WIDTH/2-1:0] w0r,
  input  logic signed [WIDTH/2-1:0] w0i,
  input  logic signed [WIDTH/2-1:0] w1r,
  input  logic signed [WIDTH/2-1:0] w1i,
  input  logic signed [WIDTH/2-1:0] w2r,
  input  logic signed [WIDTH/2-1:0] w2i,
  output logic [WIDTH-1:0]          out1r,
  output logic [WIDTH-1:0]          out1i,
  output logic [WIDTH-1:0]          out2r,
  output logic [WIDTH-1:0]          out2i,
  output logic [WIDTH-1:0]          out3r,
  output logic [WIDTH-1:0]          out3i,
  output logic [WIDTH-1:0]          out4r,
  output logic [WIDTH-1:0]          out4i
);

  localparam int SW  = WIDTH + 2;
  localparam int TWW = WIDTH / 2;
  localparam int PW  = SW + TWW + 1;

  // Full-precision products; the arithmetic shift floors, then the result wraps to WIDTH.
  function automatic logic [WIDTH-1:0] cmul_re(input logic signed [SW-1:0] xr,
                                               input logic signed [SW-1:0] xi,
                                               input logic signed [TWW-1:0] wr,
                                               input logic signed [TWW-1:0] wi);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    p = PW'(xr) * PW'(wr) - PW'(xi) * PW'(wi);
    q = p >>> TW_FRAC;
    return q[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] cmul_im(input logic signed [SW-1:0] xr,
                                               input logic signed [SW-1:0] xi,
                                               input logic signed [TWW-1:0] wr,
                                               input logic signed [TWW-1:0] wi);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    p = PW'(xr) * PW'(wi) + PW'(xi) * PW'(wr);
    q = p >>> TW_FRAC;
    return q[WIDTH-1:0];
  endfunction

  logic signed [SW-1:0]  xar, xai, xbr, xbi, xcr, xci, xdr, xdi;
  logic signed [SW-1:0]  sum_re [4];
  logic signed [SW-1:0]  sum_im [4];
  logic signed [SW-1:0]  s_re   [4];
  logic signed [SW-1:0]  s_im   [4];
  logic signed [TWW-1:0] w_re   [3];
  logic signed [TWW-1:0] w_im   [3];
  logic                  valid_1;
  logic [WIDTH-1:0]      y_re   [4];
  logic [WIDTH-1:0]      y_im   [4];

  assign xar = SW'(ar);
  assign xai = SW'(ai);
  assign xbr = SW'(br);
  assign xbi = SW'(bi);
  assign xcr = SW'(cr);
  assign xci = SW'(ci);
  assign xdr = SW'(dr);
  assign xdi = SW'(di);

  // Multiplying by -j maps (r, i) to (i, -r); by +j maps (r, i) to (-i, r).
  always_comb begin
    sum_re[0] = xar + xbr + xcr + xdr;
    sum_im[0] = xai + xbi + xci + xdi;
    sum_re[1] = xar + xbi - xcr - xdi;
    sum_im[1] = xai - xbr - xci + xdr;
    sum_re[2] = xar - xbr + xcr - xdr;
    sum_im[2] = xai - xbi + xci - xdi;
    sum_re[3] = xar - xbi - xcr + xdi;
    sum_im[3] = xai + xbr - xci - xdr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        s_re[k] <= '0;
        s_im[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        w_re[k] <= '0;
        w_im[k] <= '0;
      end
      valid_1 <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        s_re[k] <= sum_re[k];
        s_im[k] <= sum_im[k];
      end
      w_re[0] <= w0r;
      w_im[0] <= w0i;
      w_re[1] <= w1r;
      w_im[1] <= w1i;
      w_re[2] <= w2r;
      w_im[2] <= w2i;
      valid_1 <= start;
    end
  end

  always_comb begin
    y_re[0] = s_re[0][WIDTH-1:0];
    y_im[0] = s_im[0][WIDTH-1:0];
    for (int k = 1; k < 4; k++) begin
      y_re[k] = cmul_re(s_re[k], s_im[k], w_re[k-1], w_im[k-1]);
      y_im[k] = cmul_im(s_re[k], s_im[k], w_re[k-1], w_im[k-1]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done  <= 1'b0;
      out1r <= '0;
      out1i <= '0;
      out2r <= '0;
      out2i <= '0;
      out3r <= '0;
      out3i <= '0;
      out4r <= '0;
      out4i <= '0;
    end else begin
      done  <= valid_1;
      out1r <= y_re[0];
      out1i <= y_im[0];
      out2r <= y_re[1];
      out2i <= y_im[1];
      out3r <= y_re[2];
      out3i <= y_im[2];
      out4r <= y_re[3];
      out4i <= y_im[3];
    end
  end

endmodule

// File: tb/tb_r4_sdf_butterfly.sv
// tb/tb_r4_sdf_butterfly.sv - directed self-checking bench for the radix-4 butterfly and its delay line
module tb_r4_sdf_butterfly;
  import r4_sdf_butterfly_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic [31:0] ar, ai, br, bi, cr, ci, dr, di;
  logic [15:0] w0r, w0i, w1r, w1i, w2r, w2i;
  logic [31:0] out1r, out1i, out2r, out2i, out3r, out3i, out4r, out4i;

  logic        dl_en;
  logic [31:0] dl_in_re, dl_in_im;
  logic [31:0] dl4_re, dl4_im, dl1_re, dl1_im;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d [8];
    logic [15:0] w [6];
  } vec_t;

  always #5 clock = ~clock;

  r4_sdf_butterfly dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci), .dr(dr), .di(di),
    .w0r(w0r), .w0i(w0i), .w1r(w1r), .w1i(w1i), .w2r(w2r), .w2i(w2i),
    .out1r(out1r), .out1i(out1i), .out2r(out2r), .out2i(out2i),
    .out3r(out3r), .out3i(out3i), .out4r(out4r), .out4i(out4i)
  );

  sdf_delay_line #(.DEPTH(4), .WIDTH(32)) dl4 (
    .clock(clock), .enable(dl_en), .in_re(dl_in_re), .in_im(dl_in_im),
    .out_re(dl4_re), .out_im(dl4_im)
  );

  sdf_delay_line #(.DEPTH(1), .WIDTH(32)) dl1 (
    .clock(clock), .enable(dl_en), .in_re(dl_in_re), .in_im(dl_in_im),
    .out_re(dl1_re), .out_im(dl1_im)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input int a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i,
                              input int x0r, x0i, x1r, x1i, x2r, x2i);
    vec_t v;
    v.d[0] = 32'(a_r); v.d[1] = 32'(a_i); v.d[2] = 32'(b_r); v.d[3] = 32'(b_i);
    v.d[4] = 32'(c_r); v.d[5] = 32'(c_i); v.d[6] = 32'(d_r); v.d[7] = 32'(d_i);
    v.w[0] = 16'(x0r); v.w[1] = 16'(x0i); v.w[2] = 16'(x1r);
    v.w[3] = 16'(x1i); v.w[4] = 16'(x2r); v.w[5] = 16'(x2i);
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic st);
    ar = v.d[0]; ai = v.d[1]; br = v.d[2]; bi = v.d[3];
    cr = v.d[4]; ci = v.d[5]; dr = v.d[6]; di = v.d[7];
    w0r = v.w[0]; w0i = v.w[1]; w1r = v.w[2]; w1i = v.w[3]; w2r = v.w[4]; w2i = v.w[5];
    start = st;
  endtask

  function automatic longint sx32(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint sx16(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  // Reference: plain 4-point DFT in 64-bit integers, then floored twiddle rotation.
  function automatic void model(input vec_t v, output logic [31:0] y [8]);
    longint a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;
    longint xr [4];
    longint xi [4];
    longint wr, wi, pr, pi;
    a_r = sx32(v.d[0]); a_i = sx32(v.d[1]); b_r = sx32(v.d[2]); b_i = sx32(v.d[3]);
    c_r = sx32(v.d[4]); c_i = sx32(v.d[5]); d_r = sx32(v.d[6]); d_i = sx32(v.d[7]);
    xr[0] = a_r + b_r + c_r + d_r;  xi[0] = a_i + b_i + c_i + d_i;
    xr[1] = (a_r - c_r) + (b_i - d_i); xi[1] = (a_i - c_i) - (b_r - d_r);
    xr[2] = (a_r + c_r) - (b_r + d_r); xi[2] = (a_i + c_i) - (b_i + d_i);
    xr[3] = (a_r - c_r) - (b_i - d_i); xi[3] = (a_i - c_i) + (b_r - d_r);
    y[0] = xr[0][31:0];
    y[1] = xi[0][31:0];
    for (int k = 1; k < 4; k++) begin
      wr = sx16(v.w[2*k-2]);
      wi = sx16(v.w[2*k-1]);
      pr = (xr[k] * wr - xi[k] * wi) >>> 14;
      pi = (xr[k] * wi + xi[k] * wr) >>> 14;
      y[2*k]   = pr[31:0];
      y[2*k+1] = pi[31:0];
    end
  endfunction

  task automatic check_outs(input string tag, input logic [31:0] y [8]);
    check({tag, "_y1r"}, out1r, y[0]); check({tag, "_y1i"}, out1i, y[1]);
    check({tag, "_y2r"}, out2r, y[2]); check({tag, "_y2i"}, out2i, y[3]);
    check({tag, "_y3r"}, out3r, y[4]); check({tag, "_y3i"}, out3i, y[5]);
    check({tag, "_y4r"}, out4r, y[6]); check({tag, "_y4i"}, out4i, y[7]);
  endtask

  task automatic check_exp(input string tag, input int e [8]);
    logic [31:0] y [8];
    for (int k = 0; k < 8; k++) y[k] = 32'(e[k]);
    check_outs(tag, y);
  endtask

  // One isolated start; checks done timing and the hand-computed result.
  task automatic single(input string tag, input vec_t v, input int e [8]);
    drive(v, 1'b1);
    tick();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    check({tag, "_done_t1"}, {31'b0, done}, 32'd0);
    tick();
    check({tag, "_done_t2"}, {31'b0, done}, 32'd1);
    check_exp(tag, e);
    tick();
    check({tag, "_done_t3"}, {31'b0, done}, 32'd0);
  endtask

  vec_t vecs [8];
  int   twr [4] = '{16384, 0, 11585, -11585};
  int   twi [4] = '{0, -16384, -11585, -11585};
  int   vals [8];
  logic [31:0] exp_y [8];
  logic [31:0] zero_y [8];

  initial begin
    reset = 1'b1;
    dl_en = 1'b0; dl_in_re = '0; dl_in_im = '0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    for (int k = 0; k < 8; k++) zero_y[k] = '0;
    tick();
    tick();
    check("reset_done", {31'b0, done}, 32'd0);
    check_outs("reset", zero_y);
    reset = 1'b0;
    tick();

    single("dc100", mk(100,0,100,0,100,0,100,0, TW_ONE,0,TW_ONE,0,TW_ONE,0),
           '{400, 0, 0, 0, 0, 0, 0, 0});
    single("b_only", mk(0,0,1,0,0,0,0,0, TW_ONE,0,TW_ONE,0,TW_ONE,0),
           '{1, 0, 0, -1, -1, 0, 0, 1});
    single("a_only", mk(1,0,0,0,0,0,0,0, TW_ONE,0,TW_ONE,0,TW_ONE,0),
           '{1, 0, 1, 0, 1, 0, 1, 0});
    single("twid", mk(1000,0,0,0,0,0,0,0, 0,-16384, 11585,-11585, -16384,0),
           '{1000, 0, 0, -1000, 707, -708, -1000, 0});
    single("ovf", mk(32'h7FFFFFFF,0,32'h7FFFFFFF,0,32'h7FFFFFFF,0,32'h7FFFFFFF,0,
                     TW_ONE,0,TW_ONE,0,TW_ONE,0),
           '{32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0});

    // Re-launch the overflow vector to confirm no X reaches any output.
    drive(mk(32'h7FFFFFFF,0,32'h7FFFFFFF,0,32'h7FFFFFFF,0,32'h7FFFFFFF,0,
             TW_ONE,0,TW_ONE,0,TW_ONE,0), 1'b1);
    tick();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    tick();
    check("ovf_nox", {31'b0, ((^{out1r, out1i, out2r, out2i, out3r, out3i, out4r, out4i}) === 1'bx)}, 32'd0);
    tick();

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        vals[k] = (i * 1237 + k * 311 + 5) * (((i + k) % 3 == 0) ? -1 : 1);
      end
      vals[i] = vals[i] * 65536;
      vecs[i] = mk(vals[0], vals[1], vals[2], vals[3], vals[4], vals[5], vals[6], vals[7],
                   twr[i % 4], twi[i % 4], twr[(i + 1) % 4], twi[(i + 1) % 4],
                   twr[(i + 2) % 4], twi[(i + 2) % 4]);
    end

    for (int n = 0; n < 11; n++) begin
      if (n >= 2 && n < 10) begin
        check($sformatf("burst%0d_done", n - 2), {31'b0, done}, 32'd1);
        model(vecs[n - 2], exp_y);
        check_outs($sformatf("burst%0d", n - 2), exp_y);
      end else begin
        check($sformatf("burst_idle%0d_done", n), {31'b0, done}, 32'd0);
      end
      if (n < 8) drive(vecs[n], 1'b1);
      else drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
      tick();
    end

    // Mid-stream reset on the 4th start cycle: everything clears at once, nothing stale follows.
    for (int n = 0; n < 4; n++) begin
      drive(vecs[n], 1'b1);
      if (n < 3) tick();
    end
    check("pre_rst_done", {31'b0, done}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check_outs("rst_mid", zero_y);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    tick();
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("post_rst%0d_done", n), {31'b0, done}, 32'd0);
    end
    check_outs("post_rst", zero_y);

    // Delay lines: DEPTH=4 lags four writes, DEPTH=1 shows the last write.
    for (int k = 1; k <= 8; k++) begin
      dl_en = 1'b1;
      dl_in_re = 32'(k);
      dl_in_im = 32'(-k);
      tick();
      if (k >= 4) begin
        check($sformatf("dl4_re_w%0d", k), dl4_re, 32'(k - 3));
        check($sformatf("dl4_im_w%0d", k), dl4_im, 32'(3 - k));
      end
      check($sformatf("dl1_re_w%0d", k), dl1_re, 32'(k));
    end
    dl_en = 1'b0;
    dl_in_re = 32'd99;
    dl_in_im = 32'd99;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("dl4_hold%0d", k), dl4_re, 32'd5);
      check($sformatf("dl1_hold%0d", k), dl1_re, 32'd8);
    end
    dl_en = 1'b1;
    dl_in_re = 32'd9;
    dl_in_im = 32'd0;
    tick();
    check("dl4_resume", dl4_re, 32'd6);
    check("dl1_resume", dl1_re, 32'd9);
    dl_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
